// File: rtl/poly_sample_mixer.sv
// Polyphonic sample mixer.
// Once per codec frame it requests a sample from every voice and collects the
// samples from the active voices. It sums them one voice per cycle, then
// attenuates and saturates the sum. The result waits in a pending buffer until
// the next frame edge commits it to sample_out.
//
// Voice handshake: voice_ready[i] is a one-cycle valid for lane i of
// voice_samples. There is no back-pressure. Only the first ready from an
// active voice in a frame is taken. Any later ready, and any ready from an
// inactive voice, is dropped.
module poly_sample_mixer #(
    parameter int NUM_VOICES   = 4,
    parameter int SAMPLE_WIDTH = 16,
    parameter int TIMEOUT      = 255
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               new_frame,
    input  logic [NUM_VOICES-1:0]              voice_active,
    input  logic [NUM_VOICES*SAMPLE_WIDTH-1:0] voice_samples,
    input  logic [NUM_VOICES-1:0]              voice_ready,
    input  logic [1:0]                         attenuation,
    output logic                               generate_next_sample,
    output logic                               mix_ready,
    output logic [SAMPLE_WIDTH-1:0]            sample_out,
    output logic                               overrun,
    output logic                               timeout_flag,
    output logic                               clip_flag
);

    localparam int AW = SAMPLE_WIDTH + $clog2(NUM_VOICES) + 1;
    localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    localparam logic signed [AW-1:0] SAT_MAX =
        {{(AW-SAMPLE_WIDTH+1){1'b0}}, {(SAMPLE_WIDTH-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN =
        {{(AW-SAMPLE_WIDTH+1){1'b1}}, {(SAMPLE_WIDTH-1){1'b0}}};

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_SUM     = 2'd2;
    localparam logic [1:0] S_FINISH  = 2'd3;

    logic [1:0]              state;
    logic                    new_frame_q;
    logic                    frame_edge;
    logic [NUM_VOICES-1:0]   active_mask;
    logic [NUM_VOICES-1:0]   got;
    logic [NUM_VOICES-1:0]   take;
    logic [NUM_VOICES-1:0]   got_next;
    logic                    all_got;
    logic [7:0]              tcount;
    logic [7:0]              tcount_next;
    logic                    timed_out;
    logic [IW-1:0]           idx;
    logic signed [AW-1:0]    acc;
    logic signed [AW-1:0]    slot_ext;
    logic signed [AW-1:0]    shifted;
    logic [SAMPLE_WIDTH-1:0] sat_val;
    logic                    sat_clip;
    logic [SAMPLE_WIDTH-1:0] pending;
    logic [SAMPLE_WIDTH-1:0] slot [NUM_VOICES];

    // Decode the frame edge and decide what the collect stage does this cycle.
    always_comb begin
        frame_edge  = new_frame & ~new_frame_q;
        take        = voice_ready & active_mask & ~got;
        got_next    = got | take;
        all_got     = ((got_next & active_mask) == active_mask);
        tcount_next = tcount + 8'd1;
        timed_out   = (tcount_next == 8'(TIMEOUT));
        slot_ext    = {{(AW-SAMPLE_WIDTH){slot[idx][SAMPLE_WIDTH-1]}}, slot[idx]};
    end

    // Attenuate the finished sum and clamp it to the output range.
    always_comb begin
        shifted  = acc >>> attenuation;
        sat_clip = 1'b0;
        sat_val  = shifted[SAMPLE_WIDTH-1:0];
        if (shifted > SAT_MAX) begin
            sat_val  = SAT_MAX[SAMPLE_WIDTH-1:0];
            sat_clip = 1'b1;
        end else if (shifted < SAT_MIN) begin
            sat_val  = SAT_MIN[SAMPLE_WIDTH-1:0];
            sat_clip = 1'b1;
        end
    end

    // Frame sequencing: a frame edge always restarts collection, whatever the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state                <= S_IDLE;
            new_frame_q          <= 1'b0;
            active_mask          <= '0;
            got                  <= '0;
            tcount               <= '0;
            idx                  <= '0;
            acc                  <= '0;
            pending              <= '0;
            sample_out           <= '0;
            generate_next_sample <= 1'b0;
            mix_ready            <= 1'b0;
            overrun              <= 1'b0;
            timeout_flag         <= 1'b0;
            clip_flag            <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) slot[i] <= '0;
        end else begin
            new_frame_q          <= new_frame;
            generate_next_sample <= frame_edge;
            mix_ready            <= 1'b0;
            if (frame_edge) begin
                // Any mix still in flight is dropped, and the old pending value is repeated.
                if (state != S_IDLE) overrun <= 1'b1;
                sample_out  <= pending;
                active_mask <= voice_active;
                got         <= '0;
                tcount      <= '0;
                acc         <= '0;
                idx         <= '0;
                state       <= (voice_active == '0) ? S_SUM : S_COLLECT;
            end else begin
                case (state)
                    S_COLLECT: begin
                        for (int i = 0; i < NUM_VOICES; i++)
                            if (take[i]) slot[i] <= voice_samples[i*SAMPLE_WIDTH +: SAMPLE_WIDTH];
                        got    <= got_next;
                        tcount <= tcount_next;
                        if (all_got) begin
                            state <= S_SUM;
                            acc   <= '0;
                            idx   <= '0;
                        end else if (timed_out) begin
                            // A late voice contributes silence rather than a stale sample.
                            for (int i = 0; i < NUM_VOICES; i++)
                                if (active_mask[i] && !got_next[i]) slot[i] <= '0;
                            timeout_flag <= 1'b1;
                            state        <= S_SUM;
                            acc          <= '0;
                            idx          <= '0;
                        end
                    end
                    S_SUM: begin
                        if (active_mask[idx]) acc <= acc + slot_ext;
                        if (idx == IW'(NUM_VOICES-1)) state <= S_FINISH;
                        else idx <= idx + IW'(1);
                    end
                    S_FINISH: begin
                        pending   <= sat_val;
                        mix_ready <= 1'b1;
                        if (sat_clip) clip_flag <= 1'b1;
                        state     <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_poly_sample_mixer.sv
// Bench for poly_sample_mixer.
// The driver plays one frame at a time. For each frame it pushes two
// expectations: the sample_out value the frame edge should commit, and the
// clock edge on which mix_ready should fire. A separate monitor pops and
// compares both.
module tb_poly_sample_mixer;

    localparam int NV = 4;
    localparam int SW = 16;
    localparam int TO = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             new_frame = 1'b0;
    logic [NV-1:0]    voice_active = '0;
    logic [NV*SW-1:0] voice_samples = '0;
    logic [NV-1:0]    voice_ready = '0;
    logic [1:0]       attenuation = 2'd0;
    logic             generate_next_sample;
    logic             mix_ready;
    logic [SW-1:0]    sample_out;
    logic             overrun;
    logic             timeout_flag;
    logic             clip_flag;

    poly_sample_mixer #(.NUM_VOICES(NV), .SAMPLE_WIDTH(SW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .new_frame(new_frame),
        .voice_active(voice_active), .voice_samples(voice_samples),
        .voice_ready(voice_ready), .attenuation(attenuation),
        .generate_next_sample(generate_next_sample), .mix_ready(mix_ready),
        .sample_out(sample_out), .overrun(overrun),
        .timeout_flag(timeout_flag), .clip_flag(clip_flag)
    );

    // Clock and edge counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard state
    int n_checks = 0;
    int n_fail = 0;
    logic [SW-1:0] exp_q[$];
    int mix_q[$];
    int model_pending = 0;
    bit exp_over = 0, exp_tmo = 0, exp_clip = 0;
    int fv[NV];
    int fd[NV];

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sample_out"}, sample_out, 0);
        check({tag, "_gen"}, generate_next_sample, 0);
        check({tag, "_mix_ready"}, mix_ready, 0);
        check({tag, "_overrun"}, overrun, 0);
        check({tag, "_timeout"}, timeout_flag, 0);
        check({tag, "_clip"}, clip_flag, 0);
    endtask

    // Monitor: each request pulse marks the frame commit, and each mix_ready has a scheduled edge.
    always @(negedge clk) begin
        logic [SW-1:0] e;
        int m;
        if (generate_next_sample) begin
            if (exp_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL gen_spurious: request pulse with no frame issued (cycle %0d)", cyc);
            end else begin
                e = exp_q.pop_front();
                check("sample_out", $signed(sample_out), $signed(e));
            end
        end
        if (mix_ready) begin
            if (mix_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL mix_ready_spurious: mix_ready with none expected (cycle %0d)", cyc);
            end else begin
                m = mix_q.pop_front();
                check("mix_ready_cycle", cyc, m);
            end
        end
    end

    // Drive one frame. Voice i presents fv[i] so that the DUT samples it at
    // frame edge + fd[i]; fd[i]==0 means the voice never answers. Each
    // answering voice repeats one cycle later with a junk value.
    // For an aborted frame, the task returns so that the next frame edge lands
    // three cycles into SUM.
    task automatic do_frame(input logic [NV-1:0] mask, input logic [1:0] att,
                            input bit aborted);
        int e0, last_edge, sum, res, mix_edge, v;
        bit timed, clipped;
        e0 = cyc + 1;
        sum = 0; timed = 0; clipped = 0; last_edge = e0;
        for (int i = 0; i < NV; i++) begin
            if (mask[i]) begin
                if (fd[i] == 0) timed = 1;
                else begin
                    sum += fv[i];
                    if (e0 + fd[i] > last_edge) last_edge = e0 + fd[i];
                end
            end
        end
        if (timed) last_edge = e0 + TO;
        res = sum >>> att;
        if (res > 32767) begin res = 32767; clipped = 1; end
        else if (res < -32768) begin res = -32768; clipped = 1; end
        mix_edge = last_edge + NV + 1;
        exp_q.push_back(SW'(model_pending));
        if (!aborted) mix_q.push_back(mix_edge);
        new_frame = 1'b1;
        voice_active = mask;
        attenuation = att;
        voice_ready = '0;
        for (int t = 1; t <= 20; t++) begin
            @(negedge clk);
            if (aborted && cyc == last_edge + 2) break;
            if (!aborted && t > 9) break;
            new_frame = (t < 3);
            voice_active = NV'($urandom);
            for (int i = 0; i < NV; i++) begin
                v = int'($urandom_range(0, 65535)) - 32768;
                voice_ready[i] = 1'b0;
                if (fd[i] != 0 && t == fd[i]) begin
                    voice_ready[i] = 1'b1;
                    v = fv[i];
                end else if (fd[i] != 0 && t == fd[i] + 1) begin
                    voice_ready[i] = 1'b1;
                end
                voice_samples[i*SW +: SW] = SW'(v);
            end
        end
        voice_ready = '0;
        if (!aborted) begin
            while (cyc < mix_edge + 1) @(negedge clk);
            if (timed) exp_tmo = 1;
            if (clipped) exp_clip = 1;
            model_pending = res;
            check("overrun_flag", overrun, exp_over);
            check("timeout_flag", timeout_flag, exp_tmo);
            check("clip_flag", clip_flag, exp_clip);
        end
    endtask

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        int r;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        // Staggered voices summing to 260
        fv = '{100, 200, -50, 10}; fd = '{2, 3, 4, 5};
        do_frame(4'b1111, 2'd0, 0);
        // Positive saturation, then a sum that exactly fits after attenuation
        fv = '{32767, 32767, 32767, 32767}; fd = '{2, 4, 3, 5};
        do_frame(4'b1111, 2'd0, 0);
        do_frame(4'b1111, 2'd2, 0);
        // Negative saturation
        fv = '{-32768, -32768, -32768, -32768}; fd = '{5, 2, 3, 2};
        do_frame(4'b1111, 2'd1, 0);
        // Inactive voice 1 answers and must be ignored
        fv = '{1000, 5000, -3000, 777}; fd = '{2, 3, 4, 0};
        do_frame(4'b0101, 2'd0, 0);
        // Answer on the very cycle the timeout expires is still captured
        fv = '{1, 2, 3, 4}; fd = '{2, 3, 4, 8};
        do_frame(4'b1111, 2'd0, 0);
        // Voice 3 never answers
        fv = '{500, -200, 300, 9999}; fd = '{2, 3, 4, 0};
        do_frame(4'b1111, 2'd0, 0);
        // No active voices
        fv = '{10, 20, 30, 40}; fd = '{2, 3, 4, 5};
        do_frame(4'b0000, 2'd0, 0);
        // Overrun: next frame edge three cycles into SUM
        fv = '{11, 22, 33, 44}; fd = '{2, 3, 4, 2};
        do_frame(4'b1111, 2'd0, 1);
        exp_over = 1;
        fv = '{-7, 8, -9, 10}; fd = '{3, 2, 4, 5};
        do_frame(4'b1111, 2'd0, 0);
        do_frame(4'b1011, 2'd3, 0);

        // Randomised frames
        for (int n = 0; n < 24; n++) begin
            for (int i = 0; i < NV; i++) begin
                r = int'($urandom_range(0, 3));
                if (r == 0) fv[i] = ($urandom_range(0, 1) == 1) ? 32767 : -32768;
                else fv[i] = int'($urandom_range(0, 65535)) - 32768;
                fd[i] = int'($urandom_range(0, 8));
                if (fd[i] == 1) fd[i] = 2;
            end
            do_frame(NV'($urandom), 2'($urandom_range(0, 3)), 0);
        end

        // Reset during COLLECT
        exp_q.push_back(SW'(model_pending));
        new_frame = 1'b1;
        voice_active = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        new_frame = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("mid_reset");
        reset = 1'b0;
        model_pending = 0;
        exp_over = 0; exp_tmo = 0; exp_clip = 0;
        @(negedge clk);
        fv = '{1234, -234, 34, -4}; fd = '{4, 2, 3, 5};
        do_frame(4'b1111, 2'd0, 0);
        fv = '{1, 1, 1, 1}; fd = '{2, 2, 2, 2};
        do_frame(4'b0011, 2'd0, 0);

        repeat (4) @(negedge clk);
        check("exp_q_drained", exp_q.size(), 0);
        check("mix_q_drained", mix_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
